// File: rtl/matrix_ram_arbiter.sv
// Round-robin arbiter with ownership lock sharing the single-port matrix RAM
// between the host loader (H) and the matrix multiply control unit (C).
module matrix_ram_arbiter #(
    parameter int unsigned data_w    = 32,
    parameter int unsigned ram_d     = 512,
    parameter int unsigned ram_add_w = $clog2(ram_d),
    parameter int unsigned hold_max  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 h_req,
    input  logic                 h_lock,
    input  logic                 h_we,
    input  logic [ram_add_w-1:0] h_addr,
    input  logic [data_w-1:0]    h_w_data,
    output logic                 h_gnt,
    output logic                 h_r_valid,
    input  logic                 c_req,
    input  logic                 c_lock,
    input  logic                 c_we,
    input  logic [ram_add_w-1:0] c_addr,
    input  logic [data_w-1:0]    c_w_data,
    output logic                 c_gnt,
    output logic                 c_r_valid,
    output logic                 ram_we,
    output logic [ram_add_w-1:0] ram_addr,
    output logic [data_w-1:0]    ram_w_data,
    input  logic [data_w-1:0]    ram_r_data_in,
    output logic [data_w-1:0]    ram_r_data,
    output logic                 starve_err
);

    localparam int unsigned hold_w = $clog2(hold_max) + 1;
    localparam logic        RR_H   = 1'b0;
    localparam logic        RR_C   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_H = 2'd1,
        OWN_C = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rr_last;
    logic                rr_nxt;
    logic [hold_w-1:0]   hold_cnt;
    logic                hold_inc;

    // Read data is a straight broadcast to both requesters
    assign ram_r_data = ram_r_data_in;

    // Next owner selection and round-robin pointer update
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_last;
        hold_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (h_req && !c_req) begin
                    state_nxt = OWN_H;
                end else if (c_req && !h_req) begin
                    state_nxt = OWN_C;
                end else if (h_req && c_req) begin
                    state_nxt = (rr_last == RR_C) ? OWN_H : OWN_C;
                end
            end
            OWN_H: begin
                if (!h_lock) begin
                    if (c_req) begin
                        state_nxt = OWN_C;
                        rr_nxt    = RR_H;
                    end else if (!h_req) begin
                        state_nxt = IDLE;
                        rr_nxt    = RR_H;
                    end
                end
                hold_inc = c_req && (state_nxt == OWN_H);
            end
            OWN_C: begin
                if (!c_lock) begin
                    if (h_req) begin
                        state_nxt = OWN_H;
                        rr_nxt    = RR_C;
                    end else if (!c_req) begin
                        state_nxt = IDLE;
                        rr_nxt    = RR_C;
                    end
                end
                hold_inc = h_req && (state_nxt == OWN_C);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grants, read-valid and starvation bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_last    <= RR_C;
            hold_cnt   <= '0;
            starve_err <= 1'b0;
            h_gnt      <= 1'b0;
            c_gnt      <= 1'b0;
            h_r_valid  <= 1'b0;
            c_r_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_nxt;
            h_gnt     <= (state_nxt == OWN_H);
            c_gnt     <= (state_nxt == OWN_C);
            h_r_valid <= h_gnt & h_req & ~h_we;
            c_r_valid <= c_gnt & c_req & ~c_we;
            if (hold_inc) begin
                if (hold_cnt == hold_w'(hold_max - 1)) begin
                    starve_err <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + hold_w'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // RAM port mux; quiet while in reset so an abandoned burst cannot write
    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_w_data = '0;
        if (rst) begin
            if (state == OWN_H && h_req) begin
                ram_we     = h_we;
                ram_addr   = h_addr;
                ram_w_data = h_w_data;
            end else if (state == OWN_C && c_req) begin
                ram_we     = c_we;
                ram_addr   = c_addr;
                ram_w_data = c_w_data;
            end
        end
    end

endmodule
